multicycle_controller: RTL and testbench

//  Moore FSM control unit that sequences a multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
//  One shared memory port serves both fetch and data access; the FSM steers the address mux, ALU operands,

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multi-cycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Define MC_PERF_EN to build the retired-instruction counter on instret; otherwise instret is tied to 0.
module multicycle_controller #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             RegWrite,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC <= PC+4
   // DECODE   | read registers, precompute branch target
   // MEMADR   | rs1 + imm for lw/sw
   // MEMREAD  | data read at ALUOut
   // MEMWB    | load data to rd
   // MEMWRITE | store rs2 at ALUOut
   // EXECR    | R-type ALU op
   // EXECI    | I-type ALU op
   // ALUWB    | ALUOut to rd
   // BEQ      | compare rs1/rs2, take branch on Zero
   // JAL      | PC <= target, ALUOut <= OldPC+4
   // TRAP     | unsupported opcode, held until reset
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
   } state_t;

   typedef struct packed {
      logic       pcUpdate;
      logic       branch;
      logic       adrSrc;
      logic       memWrite;
      logic       irWrite;
      logic       regWrite;
      logic       illegal;
      logic [1:0] resultSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
   } ctrl_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   state_t state;
   ctrl_t  ctrl;

   function automatic state_t nextOf(input state_t s, input logic [6:0] o);
      state_t n;
      n = s;
      case (s)
         FETCH:    n = DECODE;
         DECODE: begin
            case (o)
               OP_LW, OP_SW: n = MEMADR;
               OP_R:         n = EXECR;
               OP_I:         n = EXECI;
               OP_BEQ:       n = BEQ;
               OP_JAL:       n = JAL;
               default:      n = TRAP;
            endcase
         end
         MEMADR:   n = (o == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  n = MEMWB;
         EXECR, EXECI, JAL:          n = ALUWB;
         MEMWB, MEMWRITE, ALUWB, BEQ: n = FETCH;
         TRAP:     n = TRAP;
         default:  n = FETCH;
      endcase
      return n;
   endfunction

   function automatic ctrl_t ctrlOf(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.irWrite   = 1'b1;
            c.pcUpdate  = 1'b1;
            c.aluSrcB   = 2'b10;
            c.resultSrc = 2'b10;
         end
         DECODE: begin
            c.aluSrcA = 2'b01;
            c.aluSrcB = 2'b01;
         end
         MEMADR: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
         end
         MEMREAD:  c.adrSrc = 1'b1;
         MEMWB: begin
            c.resultSrc = 2'b01;
            c.regWrite  = 1'b1;
         end
         MEMWRITE: begin
            c.adrSrc   = 1'b1;
            c.memWrite = 1'b1;
         end
         EXECR: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b10;
         end
         EXECI: begin
            c.aluSrcA = 2'b10;
            c.aluSrcB = 2'b01;
            c.aluOp   = 2'b10;
         end
         ALUWB:    c.regWrite = 1'b1;
         BEQ: begin
            c.aluSrcA = 2'b10;
            c.aluOp   = 2'b01;
            c.branch  = 1'b1;
         end
         JAL: begin
            c.aluSrcA  = 2'b01;
            c.aluSrcB  = 2'b10;
            c.pcUpdate = 1'b1;
         end
         TRAP:     c.illegal = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   // Control word is registered alongside the state so each output is a clean flop output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         ctrl  <= ctrlOf(FETCH);
      end else begin
         state <= nextOf(state, op);
         ctrl  <= ctrlOf(nextOf(state, op));
      end
   end

   // Reset parks the control word at FETCH, so its write enables are masked while reset is low.
   assign PCWrite   = reset & (ctrl.pcUpdate | (ctrl.branch & Zero));
   assign IRWrite   = reset & ctrl.irWrite;
   assign MemWrite  = reset & ctrl.memWrite;
   assign RegWrite  = reset & ctrl.regWrite;
   assign AdrSrc    = ctrl.adrSrc;
   assign ResultSrc = ctrl.resultSrc;
   assign ALUSrcA   = ctrl.aluSrcA;
   assign ALUSrcB   = ctrl.aluSrcB;
   assign illegal   = ctrl.illegal;

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (ctrl.aluOp)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

`ifdef MC_PERF_EN
   logic [CNT_W-1:0] retCnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         retCnt <= '0;
      else if (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ)
         retCnt <= retCnt + CNT_W'(1);
   end

   assign instret = retCnt;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors from a state-sequence model,
// queued per instruction and compared cycle by cycle; also covers reset, TRAP and the retire counter.
module tb_multicycle_controller;
   localparam int CNT_W = 4;
`ifdef MC_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MW = 4, S_MWR = 5;
   localparam int S_ER = 6, S_EI = 7, S_AW = 8, S_B = 9, S_J = 10, S_T = 11;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [6:0] op = 7'b0000011;
   logic [2:0] funct3 = 3'b000;
   logic funct7b5 = 1'b0;
   logic Zero = 1'b0;
   logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [CNT_W-1:0] instret;

   multicycle_controller #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef logic [16:0] vec_t;
   vec_t actual;
   assign actual = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ImmSrc, ALUControl, RegWrite, illegal};

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7b5;
      logic       zero;
      logic [2:0] expAlu;
   } row_t;

   row_t rows[13];
   vec_t expQ[$];
   int   stQ[$];
   string stName[12] = '{"FETCH", "DECODE", "MEMADR", "MEMREAD", "MEMWB", "MEMWRITE",
                         "EXECR", "EXECI", "ALUWB", "BEQ", "JAL", "TRAP"};
   int nChecks = 0;
   int nErrors = 0;
   int expRet = 0;

   function automatic vec_t expVec(int st, logic [6:0] o, logic [2:0] aluExe, logic z, bit inRst);
      logic pcw, adr, mw, ir, rw, ill;
      logic [1:0] res, sa, sb, imm;
      logic [2:0] alu;
      {pcw, adr, mw, ir, rw, ill} = '0;
      res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
      case (st)
         S_F:   begin pcw = 1; ir = 1; sb = 2'b10; res = 2'b10; end
         S_D:   begin sa = 2'b01; sb = 2'b01; end
         S_MA:  begin sa = 2'b10; sb = 2'b01; end
         S_MR:  adr = 1;
         S_MW:  begin res = 2'b01; rw = 1; end
         S_MWR: begin adr = 1; mw = 1; end
         S_ER:  begin sa = 2'b10; alu = aluExe; end
         S_EI:  begin sa = 2'b10; sb = 2'b01; alu = aluExe; end
         S_AW:  rw = 1;
         S_B:   begin sa = 2'b10; alu = 3'b001; pcw = z; end
         S_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         S_T:   ill = 1;
         default: ;
      endcase
      if (inRst) begin pcw = 0; ir = 0; mw = 0; rw = 0; end
      case (o)
         7'b0100011: imm = 2'b01;
         7'b1100011: imm = 2'b10;
         7'b1101111: imm = 2'b11;
         default:    imm = 2'b00;
      endcase
      return {pcw, adr, mw, ir, res, sa, sb, imm, alu, rw, ill};
   endfunction

   task automatic checkVec(string name, vec_t got, vec_t exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %b expected %b (PCW,Adr,MemW,IRW,Res,SrcA,SrcB,Imm,ALU,RegW,ill)",
                  name, got, exp);
      end
   endtask

   task automatic checkRet(string name);
      nChecks++;
      if (int'(instret) != expRet) begin
         nErrors++;
         $display("FAIL %s: instret got %0d expected %0d", name, instret, expRet);
      end
   endtask

   task automatic pushState(int st, row_t r);
      expQ.push_back(expVec(st, r.op, r.expAlu, r.zero, 1'b0));
      stQ.push_back(st);
   endtask

   task automatic pushInstr(row_t r, int nTrap);
      pushState(S_F, r);
      pushState(S_D, r);
      case (r.op)
         7'b0000011: begin pushState(S_MA, r); pushState(S_MR, r); pushState(S_MW, r); end
         7'b0100011: begin pushState(S_MA, r); pushState(S_MWR, r); end
         7'b0110011: begin pushState(S_ER, r); pushState(S_AW, r); end
         7'b0010011: begin pushState(S_EI, r); pushState(S_AW, r); end
         7'b1100011: pushState(S_B, r);
         7'b1101111: begin pushState(S_J, r); pushState(S_AW, r); end
         default: for (int k = 0; k < nTrap; k++) pushState(S_T, r);
      endcase
   endtask

   // Runs up to maxCycles of an instruction (all when negative); unconsumed expectations are dropped.
   task automatic runRow(row_t r, int maxCycles, int nTrap);
      int done;
      vec_t e;
      int st;
      done = 0;
      pushInstr(r, nTrap);
      while (expQ.size() > 0 && (maxCycles < 0 || done < maxCycles)) begin
         @(negedge clk);
         op = r.op; funct3 = r.f3; funct7b5 = r.f7b5; Zero = r.zero;
         #1;
         e  = expQ.pop_front();
         st = stQ.pop_front();
         checkVec($sformatf("op=%b %s", r.op, stName[st]), actual, e);
         done++;
      end
      expQ.delete();
      stQ.delete();
   endtask

   task automatic runFull(row_t r);
      runRow(r, -1, 0);
      @(posedge clk);
      #1;
      if (PERF) expRet = (expRet + 1) % (1 << CNT_W);
      checkRet($sformatf("instret after op=%b", r.op));
   endtask

   task automatic resetHold(string name, int cycles, row_t r);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         #1;
         checkVec(name, actual, expVec(S_F, r.op, 3'b000, r.zero, 1'b1));
      end
   endtask

   task automatic release_();
      @(posedge clk);
      #2 reset = 1'b1;
      expRet = 0;
      checkRet("instret after reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t trapRow;
      //              op           f3      f7b5  zero  expAlu
      rows[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b1, 3'b000}; // lw
      rows[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000}; // sw
      rows[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b1, 3'b001}; // sub
      rows[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000}; // add
      rows[4]  = '{7'b0110011, 3'b111, 1'b0, 1'b1, 3'b010}; // and
      rows[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011}; // or
      rows[6]  = '{7'b0110011, 3'b010, 1'b0, 1'b1, 3'b101}; // slt
      rows[7]  = '{7'b0110011, 3'b100, 1'b1, 1'b0, 3'b000}; // xor -> add
      rows[8]  = '{7'b0010011, 3'b000, 1'b1, 1'b1, 3'b000}; // addi, op[5]=0 keeps add
      rows[9]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 3'b011}; // ori
      rows[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3'b000}; // beq taken
      rows[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3'b000}; // beq not taken
      rows[12] = '{7'b1101111, 3'b000, 1'b0, 1'b1, 3'b000}; // jal

      resetHold("reset hold", 3, rows[0]);
      checkRet("instret in reset");
      release_();

      for (int i = 0; i < 13; i++) runFull(rows[i]);

      // lw abandoned by reset in MEMREAD: its MEMWB write must never appear
      runRow(rows[0], 3, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkVec("reset mid lw", actual, expVec(S_F, rows[0].op, 3'b000, rows[0].zero, 1'b1));
      resetHold("reset mid lw hold", 2, rows[0]);
      release_();
      runFull(rows[1]);

      trapRow = '{7'b1111111, 3'b000, 1'b0, 1'b1, 3'b000};
      runRow(trapRow, -1, 10);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkVec("reset from TRAP", actual, expVec(S_F, trapRow.op, 3'b000, trapRow.zero, 1'b1));
      release_();
      runFull(rows[3]);

      for (int i = 0; i < 17; i++) runFull(rows[8 + (i % 2)]);

      // reset asserted during EXECI: no ALUWB write and the counter clears
      runRow(rows[8], 3, 0);
      #1 reset = 1'b0;
      #1;
      expRet = 0;
      checkRet("instret reset in EXECI");
      resetHold("reset in EXECI hold", 2, rows[8]);
      release_();
      runFull(rows[0]);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
